// File: rtl/des_byte_stream_io.sv
// Byte-stream wrapper around the combinational DES core: gathers 8 bytes, holds the core inputs for SETTLE_CYCLES, then streams the 8 result bytes.
// Latency: SETTLE_CYCLES clocks from byte-7 accept to OUT_VALID; backpressure: IN_READY low in EVAL/SEND, OUT_DATA held while OUT_READY low.
module des_byte_stream_io #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        KEY_SEL,
    output logic [64:1] PLAIN_TEXT,
    output logic        ADDRESS,
    output logic        CHIP_SELECT_BAR,
    input  logic [64:1] CIPHER_TEXT,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        BUSY
);

    typedef enum logic [1:0] {ST_LOAD, ST_EVAL, ST_SEND} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       byte_cnt;
    logic [CNT_W-1:0] settle_cnt;
    logic [63:0]      out_sr;
    logic             in_acc, out_acc, last_byte, settle_done;

    assign IN_READY    = (state == ST_LOAD);
    assign BUSY        = (state != ST_LOAD);
    assign OUT_DATA    = out_sr[63:56];
    assign in_acc      = IN_VALID && (state == ST_LOAD);
    assign out_acc     = OUT_VALID && OUT_READY && (state == ST_SEND);
    assign last_byte   = (byte_cnt == 3'd7);
    assign settle_done = (state == ST_EVAL) && (settle_cnt == SETTLE_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (in_acc && last_byte)  state_nxt = ST_EVAL;
            ST_EVAL: if (settle_done)          state_nxt = ST_SEND;
            ST_SEND: if (out_acc && last_byte) state_nxt = ST_LOAD;
            default:                           state_nxt = ST_LOAD;
        endcase
    end

    // Core enable is registered so the DES inputs see a clean, glitch-free window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt        <= 3'd0;
            settle_cnt      <= '0;
            PLAIN_TEXT      <= '0;
            ADDRESS         <= 1'b0;
            CHIP_SELECT_BAR <= 1'b1;
            out_sr          <= '0;
            OUT_VALID       <= 1'b0;
        end else begin
            if (in_acc) begin
                PLAIN_TEXT <= {PLAIN_TEXT[56:1], IN_DATA};
                if (byte_cnt == 3'd0) begin
                    ADDRESS <= KEY_SEL;
                end
                if (last_byte) begin
                    byte_cnt        <= 3'd0;
                    settle_cnt      <= '0;
                    CHIP_SELECT_BAR <= 1'b0;
                end else begin
                    byte_cnt <= byte_cnt + 3'd1;
                end
            end

            if (state == ST_EVAL) begin
                settle_cnt <= settle_cnt + 1'b1;
                if (settle_done) begin
                    out_sr          <= CIPHER_TEXT;
                    OUT_VALID       <= 1'b1;
                    CHIP_SELECT_BAR <= 1'b1;
                end
            end

            if (out_acc) begin
                out_sr <= {out_sr[55:0], 8'h00};
                if (last_byte) begin
                    byte_cnt  <= 3'd0;
                    OUT_VALID <= 1'b0;
                end else begin
                    byte_cnt <= byte_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/des_byte_stream_io.md
Name: des_byte_stream_io

Overview:
- Byte-stream front/back end for the combinational DES datapath.
- Upstream side: assembles eight input bytes into one 64-bit block, drives PLAIN_TEXT, ADDRESS and CHIP_SELECT_BAR into the DES core, and holds them stable for a fixed settle window.
- Downstream side: captures CIPHER_TEXT and serialises it as eight output bytes over a valid/ready handshake.
- Only clocked element between the host byte bus and the core; one block in flight at a time.

Parameters:
SETTLE_CYCLES, 4, clock cycles PLAIN_TEXT/ADDRESS are held with CHIP_SELECT_BAR low before CIPHER_TEXT is sampled; legal range 1..255
CNT_W, 8, width of settle counter; must hold SETTLE_CYCLES

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_DATA  input  8  plaintext byte, first byte = most significant
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  block accepts a byte this cycle
KEY_SEL  input  1  key-schedule select, sampled with first byte of a block
PLAIN_TEXT  output  64 ([64:1])  block to DES core
ADDRESS  output  1  key-schedule select to DES core
CHIP_SELECT_BAR  output  1  active-low enable to DES core
CIPHER_TEXT  input  64 ([64:1])  result from DES core
OUT_DATA  output  8  ciphertext byte, most significant first
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  consumer accepts byte
BUSY  output  1  high in EVAL or SEND

Behaviour:
- Reset (RST_N low, asynchronous, any state): state=LOAD, byte count=0, PLAIN_TEXT=0, ADDRESS=0, CHIP_SELECT_BAR=1, OUT_DATA=0, OUT_VALID=0, BUSY=0. A partial block or partial output is discarded. No byte is accepted or emitted until the first rising edge after RST_N rises.
- States: LOAD -> EVAL -> SEND -> LOAD.
- LOAD:
  - IN_READY=1 (decoded from state); CHIP_SELECT_BAR=1.
  - Each IN_VALID&IN_READY edge performs PLAIN_TEXT <= {PLAIN_TEXT[56:1], IN_DATA} and increments the byte count. The first byte therefore ends in [64:57].
  - On the edge accepting byte 0, ADDRESS <= KEY_SEL. KEY_SEL is ignored for bytes 1..7.
  - On the edge accepting byte 7, go to EVAL, clear the settle counter and clear the byte count.
- EVAL:
  - IN_READY=0, CHIP_SELECT_BAR=0, BUSY=1. PLAIN_TEXT and ADDRESS are frozen.
  - The counter increments each cycle.
  - At the edge ending the SETTLE_CYCLES-th EVAL cycle: output shift register <= CIPHER_TEXT, OUT_VALID <= 1, CHIP_SELECT_BAR <= 1, go to SEND.
  - Latency from byte-7 accept edge to OUT_VALID high is exactly SETTLE_CYCLES cycles.
- SEND:
  - IN_READY=0, BUSY=1. OUT_DATA = shift register [64:57], registered.
  - While OUT_VALID&!OUT_READY, OUT_DATA is held stable.
  - Each OUT_VALID&OUT_READY edge shifts the register left by 8 and increments the byte count.
  - On the edge accepting byte 7: OUT_VALID <= 0, byte count <= 0, go to LOAD. IN_READY rises in the following cycle.
  - Back-to-back OUT_READY=1 yields 8 consecutive bytes.
- Simultaneous events:
  - IN_VALID in EVAL/SEND is ignored, with no data loss; the producer must hold the byte.
  - KEY_SEL changes mid-block have no effect.
  - CIPHER_TEXT changes outside the sampling edge have no effect.
- Throughput: minimum 8 + SETTLE_CYCLES + 8 cycles per block. There is no overlap of load and send.
- PLAIN_TEXT keeps the last block after SEND. It is overwritten byte by byte during the next LOAD.

Test Plan:
- Load 01 23 45 67 89 AB CD EF with IN_VALID=1 continuous and KEY_SEL=1 on byte 0 -> after 8 edges PLAIN_TEXT=0123456789ABCDEF, ADDRESS=1, CHIP_SELECT_BAR=0 for exactly 4 cycles, then OUT_VALID=1.
- Bench stub drives CIPHER_TEXT=85E813540F0AB405 only while CHIP_SELECT_BAR=0 (X otherwise), with OUT_READY=1 -> OUT_DATA sequence 85 E8 13 54 0F 0A B4 05 on 8 consecutive cycles, then IN_READY=1 next cycle.
- OUT_READY toggled 1,0,0,1,... -> each byte held stable across stall cycles; no byte duplicated or skipped; all 8 delivered in order.
- IN_VALID gaps (bytes every 3rd cycle) and KEY_SEL=0 at byte 0, then KEY_SEL toggling afterwards -> same assembled block; ADDRESS=0 throughout.
- RST_N pulsed low asynchronously after byte 5 of load, and again after output byte 3 -> outputs at reset values immediately. The next full 8-byte block then processes correctly from byte 0.
- SETTLE_CYCLES=1 build -> OUT_VALID rises exactly 1 cycle after the byte-7 accept edge; CHIP_SELECT_BAR low for exactly 1 cycle.
